// File: rtl/opcode_predecode_queue.sv
// opcode_predecode_queue
// Assembles a 6502-style instruction byte stream into complete instructions
// (opcode plus 0-2 operand bytes), decodes each opcode into a command and an
// addressing mode, and queues the results in a DEPTH-entry FIFO.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous discard of queue and any partial instruction
//   byte_valid/ready    input byte handshake, byte_data is the stream byte
//   instr_valid/ready   output handshake on the FIFO head
//   instr_opcode/cmd/mode/len/op_lo/op_hi/illegal   head instruction fields
//   count               FIFO occupancy
//
// Command encoding (groups of eight follow the opcode aaa field):
//   0 NOP 1 BRK 2 JSR 3 RTI 4 RTS 5 JMP 6 BIT 7 STY
//   8..15  ORA AND EOR ADC STA LDA CMP SBC
//   16..23 ASL ROL LSR ROR STX LDX DEC INC
//   24..31 BPL BMI BVC BVS BCC BCS BNE BEQ
//   32..39 PHP PLP PHA PLA DEY TAY INY INX
//   40..47 CLC SEC CLI SEI TYA CLV CLD SED
//   48 LDY 49 CPY 50 CPX 51 TXA 52 TXS 53 TAX 54 TSX 55 DEX
// Mode encoding, ordered so that length follows from the code:
//   0 impl 1 A | 2 IMM 3 zpg 4 zpgX 5 zpgY 6 Xind 7 indY 8 rel | 9 abs 10 absX 11 absY 12 ind
module opcode_predecode_queue #(
    parameter int DEPTH        = 4,
    parameter int CMD_W        = 6,
    parameter int MODE_W       = 4,
    parameter int FLAG_ILLEGAL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [7:0]                   instr_opcode,
    output logic [CMD_W-1:0]             instr_cmd,
    output logic [MODE_W-1:0]            instr_mode,
    output logic [1:0]                   instr_len,
    output logic [7:0]                   instr_op_lo,
    output logic [7:0]                   instr_op_hi,
    output logic                         instr_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam int C_NOP = 0,  C_BRK = 1,  C_JSR = 2,  C_RTI = 3,  C_RTS = 4,  C_JMP = 5;
    localparam int C_BIT = 6,  C_STY = 7,  C_LDY = 48, C_CPY = 49, C_CPX = 50, C_TXA = 51;
    localparam int C_TXS = 52, C_TAX = 53, C_TSX = 54, C_DEX = 55;

    localparam int M_IMPL = 0, M_ACC = 1, M_IMM = 2, M_ZPG = 3, M_ZPGX = 4, M_ZPGY = 5;
    localparam int M_XIND = 6, M_INDY = 7, M_REL = 8, M_ABS = 9, M_ABSX = 10, M_ABSY = 11;
    localparam int M_IND = 12;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [MODE_W-1:0] mode;
        logic [1:0]        len;
        logic              illegal;
    } dec_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [CMD_W-1:0]  cmd;
        logic [MODE_W-1:0] mode;
        logic [1:0]        len;
        logic [7:0]        op_lo;
        logic [7:0]        op_hi;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {S_OPC = 2'd0, S_LO = 2'd1, S_HI = 2'd2} state_t;

    function automatic logic [CMD_W-1:0] cmd_of(input int c);
        return CMD_W'(c);
    endfunction

    function automatic logic [MODE_W-1:0] mode_of(input int m);
        return MODE_W'(m);
    endfunction

    // Eight consecutive commands indexed by the opcode aaa field.
    function automatic logic [CMD_W-1:0] grp(input int base, input logic [2:0] idx);
        return CMD_W'(base + int'(idx));
    endfunction

    // Instruction length follows from the ordering of the mode codes.
    function automatic logic [1:0] mode_len(input logic [MODE_W-1:0] m);
        logic [1:0] l;
        if (m <= mode_of(M_ACC)) l = 2'd1;
        else if (m <= mode_of(M_REL)) l = 2'd2;
        else l = 2'd3;
        return l;
    endfunction

    // Opcode split as aaa_bbb_cc: cc picks the group, bbb the mode, aaa the operation.
    function automatic dec_t decode(input logic [7:0] op);
        dec_t       d;
        logic [2:0] aaa;
        logic [2:0] bbb;
        aaa       = op[7:5];
        bbb       = op[4:2];
        d.cmd     = cmd_of(C_NOP);
        d.mode    = mode_of(M_IMPL);
        d.illegal = 1'b0;
        case (op[1:0])
            2'b01: begin
                d.cmd = grp(8, aaa);
                case (bbb)
                    3'd0:    d.mode = mode_of(M_XIND);
                    3'd1:    d.mode = mode_of(M_ZPG);
                    3'd2:    d.mode = mode_of(M_IMM);
                    3'd3:    d.mode = mode_of(M_ABS);
                    3'd4:    d.mode = mode_of(M_INDY);
                    3'd5:    d.mode = mode_of(M_ZPGX);
                    3'd6:    d.mode = mode_of(M_ABSY);
                    default: d.mode = mode_of(M_ABSX);
                endcase
            end
            2'b10: begin
                d.cmd = grp(16, aaa);
                case (bbb)
                    3'd0: d.mode = mode_of(M_IMM);
                    3'd1: d.mode = mode_of(M_ZPG);
                    3'd2: begin
                        if (!aaa[2]) begin
                            d.mode = mode_of(M_ACC);
                        end else begin
                            d.mode = mode_of(M_IMPL);
                            case (aaa[1:0])
                                2'd0:    d.cmd = cmd_of(C_TXA);
                                2'd1:    d.cmd = cmd_of(C_TAX);
                                2'd2:    d.cmd = cmd_of(C_DEX);
                                default: d.cmd = cmd_of(C_NOP);
                            endcase
                        end
                    end
                    3'd3: d.mode = mode_of(M_ABS);
                    // STX/LDX index with Y instead of X
                    3'd5: d.mode = (aaa[2:1] == 2'b10) ? mode_of(M_ZPGY) : mode_of(M_ZPGX);
                    3'd6: begin
                        d.mode = mode_of(M_IMPL);
                        if (aaa == 3'd4) d.cmd = cmd_of(C_TXS);
                        else if (aaa == 3'd5) d.cmd = cmd_of(C_TSX);
                        else d.cmd = cmd_of(C_NOP);
                    end
                    3'd7: d.mode = (aaa[2:1] == 2'b10) ? mode_of(M_ABSY) : mode_of(M_ABSX);
                    default: begin
                        d.cmd  = cmd_of(C_NOP);
                        d.mode = mode_of(M_IMPL);
                    end
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd4: begin d.cmd = grp(24, aaa); d.mode = mode_of(M_REL);  end
                    3'd2: begin d.cmd = grp(32, aaa); d.mode = mode_of(M_IMPL); end
                    3'd6: begin d.cmd = grp(40, aaa); d.mode = mode_of(M_IMPL); end
                    3'd0: begin
                        case (aaa)
                            3'd0:    begin d.cmd = cmd_of(C_BRK); d.mode = mode_of(M_IMPL); end
                            3'd1:    begin d.cmd = cmd_of(C_JSR); d.mode = mode_of(M_ABS);  end
                            3'd2:    begin d.cmd = cmd_of(C_RTI); d.mode = mode_of(M_IMPL); end
                            3'd3:    begin d.cmd = cmd_of(C_RTS); d.mode = mode_of(M_IMPL); end
                            3'd4:    begin d.cmd = cmd_of(C_NOP); d.mode = mode_of(M_IMM);  end
                            3'd5:    begin d.cmd = cmd_of(C_LDY); d.mode = mode_of(M_IMM);  end
                            3'd6:    begin d.cmd = cmd_of(C_CPY); d.mode = mode_of(M_IMM);  end
                            default: begin d.cmd = cmd_of(C_CPX); d.mode = mode_of(M_IMM);  end
                        endcase
                    end
                    default: begin
                        case (aaa)
                            3'd0:    d.cmd = cmd_of(C_NOP);
                            3'd1:    d.cmd = cmd_of(C_BIT);
                            3'd2:    d.cmd = cmd_of(C_JMP);
                            3'd3:    d.cmd = cmd_of(C_JMP);
                            3'd4:    d.cmd = cmd_of(C_STY);
                            3'd5:    d.cmd = cmd_of(C_LDY);
                            3'd6:    d.cmd = cmd_of(C_CPY);
                            default: d.cmd = cmd_of(C_CPX);
                        endcase
                        case (bbb)
                            3'd1:    d.mode = mode_of(M_ZPG);
                            3'd3:    d.mode = (aaa == 3'd3) ? mode_of(M_IND) : mode_of(M_ABS);
                            3'd5:    d.mode = mode_of(M_ZPGX);
                            default: d.mode = mode_of(M_ABSX);
                        endcase
                    end
                endcase
            end
            default: d.illegal = (FLAG_ILLEGAL != 0) ? 1'b1 : 1'b0;
        endcase
        d.len = mode_len(d.mode);
        return d;
    endfunction

    state_t            r_state;
    logic [7:0]        r_opcode;
    logic [CMD_W-1:0]  r_cmd;
    logic [MODE_W-1:0] r_mode;
    logic [1:0]        r_len;
    logic [7:0]        r_lo;
    logic              r_illegal;
    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    dec_t   w_dec;
    entry_t w_push_data;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_xfer;
    logic   w_valid;

    assign w_valid    = (r_count != '0);
    assign byte_ready = (r_count < CNT_W'(DEPTH)) & ~flush;
    assign w_xfer     = byte_valid & byte_ready;
    assign w_pop      = w_valid & instr_ready & ~flush;
    assign w_dec      = decode(byte_data);

    // Build the FIFO entry completed by this cycle's byte, if any.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            S_OPC: begin
                if (w_xfer && (w_dec.len == 2'd1)) begin
                    w_push              = 1'b1;
                    w_push_data.opcode  = byte_data;
                    w_push_data.cmd     = w_dec.cmd;
                    w_push_data.mode    = w_dec.mode;
                    w_push_data.len     = w_dec.len;
                    w_push_data.illegal = w_dec.illegal;
                end else begin
                    w_push = 1'b0;
                end
            end
            S_LO, S_HI: begin
                if (w_xfer && ((r_state == S_HI) || (r_len == 2'd2))) begin
                    w_push              = 1'b1;
                    w_push_data.opcode  = r_opcode;
                    w_push_data.cmd     = r_cmd;
                    w_push_data.mode    = r_mode;
                    w_push_data.len     = r_len;
                    w_push_data.illegal = r_illegal;
                    w_push_data.op_lo   = (r_state == S_HI) ? r_lo : byte_data;
                    w_push_data.op_hi   = (r_state == S_HI) ? byte_data : 8'h00;
                end else begin
                    w_push = 1'b0;
                end
            end
            default: w_push = 1'b0;
        endcase
    end

    // Assembler FSM: holds the decoded opcode and first operand of a partial instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_OPC;
            r_opcode  <= 8'h00;
            r_cmd     <= '0;
            r_mode    <= '0;
            r_len     <= 2'd0;
            r_lo      <= 8'h00;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state   <= S_OPC;
            r_opcode  <= 8'h00;
            r_cmd     <= '0;
            r_mode    <= '0;
            r_len     <= 2'd0;
            r_lo      <= 8'h00;
            r_illegal <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                S_OPC: begin
                    if (w_dec.len != 2'd1) begin
                        r_opcode  <= byte_data;
                        r_cmd     <= w_dec.cmd;
                        r_mode    <= w_dec.mode;
                        r_len     <= w_dec.len;
                        r_illegal <= w_dec.illegal;
                        r_state   <= S_LO;
                    end else begin
                        r_state <= S_OPC;
                    end
                end
                S_LO: begin
                    if (r_len == 2'd2) begin
                        r_state <= S_OPC;
                    end else begin
                        r_lo    <= byte_data;
                        r_state <= S_HI;
                    end
                end
                default: r_state <= S_OPC;
            endcase
        end
    end

    // FIFO pointers and occupancy; flush empties the queue ahead of any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; a push never targets the head slot unless the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // Head fields read as zero while the FIFO is empty so reset leaves all outputs clear.
    assign w_head        = r_mem[r_rd_ptr];
    assign instr_valid   = w_valid;
    assign instr_opcode  = w_valid ? w_head.opcode  : 8'h00;
    assign instr_cmd     = w_valid ? w_head.cmd     : '0;
    assign instr_mode    = w_valid ? w_head.mode    : '0;
    assign instr_len     = w_valid ? w_head.len     : 2'd0;
    assign instr_op_lo   = w_valid ? w_head.op_lo   : 8'h00;
    assign instr_op_hi   = w_valid ? w_head.op_hi   : 8'h00;
    assign instr_illegal = w_valid ? w_head.illegal : 1'b0;
    assign count         = r_count;

endmodule

// File: doc/opcode_predecode_queue.md
Name: opcode_predecode_queue

Overview:
- Sits between the memory byte stream and the control-logic timing generator.
- Assembles raw instruction bytes into complete instructions: opcode byte plus 0–2 operand bytes.
- Decodes each opcode into CMD/ADDRESS using the shared control package encodings.
- Buffers completed instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a flush for taken branches, jumps and interrupts.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- CMD_W, 6: width of the CMD field.
- MODE_W, 4: width of the ADDRESS (addressing-mode) field.
- FLAG_ILLEGAL, 1: 1 drives instr_illegal for opcodes with opcode[1:0]==2'b11; 0 ties instr_illegal to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of the FIFO and any partial instruction.
- byte_valid  in  1  byte_data holds a valid stream byte.
- byte_data  in  8  instruction stream byte.
- byte_ready  out  1  block accepts byte_data this cycle.
- instr_valid  out  1  FIFO head holds an instruction.
- instr_ready  in  1  consumer pops the head this cycle.
- instr_opcode  out  8  head opcode.
- instr_cmd  out  CMD_W  head decoded command.
- instr_mode  out  MODE_W  head decoded addressing mode.
- instr_len  out  2  head length in bytes: 1, 2 or 3.
- instr_op_lo  out  8  first operand byte; 0 if len<2.
- instr_op_hi  out  8  second operand byte; 0 if len<3.
- instr_illegal  out  1  head opcode is in the unmapped group.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, any state):
  - FIFO empty, count=0, assembler state=OPC.
  - All instr_* outputs 0, instr_valid=0.
  - Operand and length registers 0.
- Handshakes:
  - Input byte transfer = byte_valid & byte_ready.
  - Output pop = instr_valid & instr_ready.
  - instr_valid = (count != 0). Head fields stay stable while instr_valid=1 and instr_ready=0.
- byte_ready = (count < DEPTH) & ~flush. It depends only on registered state and flush, never on byte_valid.
- Assembler FSM:
  - OPC: on transfer, latch opcode and decode combinationally.
    - len=1 → push this cycle; stay in OPC.
    - len=2 or 3 → go to LO.
  - LO: on transfer, latch op_lo.
    - len=2 → push; go to OPC.
    - len=3 → go to HI.
  - HI: on transfer, latch op_hi, push, go to OPC.
  - No transfer → hold state.
- Length by mode:
  - impl, A → 1.
  - IMMEDIATE, zpg, zpgX, zpgY, Xind, indY, rel → 2.
  - abs, absX, absY, ind → 3.
- Unmapped group (opcode[1:0]==2'b11): CMD=NOP, mode=impl, len=1, illegal flag per FLAG_ILLEGAL.
- Push semantics:
  - The entry is written at the clock edge of the final byte transfer.
  - instr_valid rises the cycle after that edge when the FIFO was empty. Minimum latency from last byte to instr_valid = 1 cycle.
- Simultaneous push and pop: count unchanged; pointers both advance; the popped entry is never the one being written.
- Full: byte_ready=0, so no push can occur while count==DEPTH. A pop while full re-enables byte_ready the next cycle.
- Empty: a pop with instr_valid=0 is ignored. Pointers wrap modulo DEPTH.
- flush (priority over all other events):
  - count→0, pointers→0, FSM→OPC, partial operands cleared.
  - Any byte or pop presented in the flush cycle is discarded.
  - instr_valid=0 in the following cycle.
- Decode is registered into the FIFO entry. No combinational path from byte_data to any instr_* output.

Test Plan:
- Reset, then stream A9 42 → one entry: cmd=LDA, mode=IMMEDIATE, len=2, op_lo=0x42, op_hi=0; instr_valid high 1 cycle after the 0x42 transfer.
- Stream 4C 34 12 with instr_ready=0 → entry cmd=JMP, mode=abs, len=3, op_lo=0x34, op_hi=0x12; fields held stable until instr_ready=1, then count→0.
- DEPTH=4, instr_ready=0, stream EA ×5 → four NOP entries (len=1), count=4, byte_ready=0 with the 5th byte held; one pop → the 5th byte is accepted the next cycle and count returns to 4.
- Stream AD 00, then assert flush for one cycle, then E8 → count=0 after flush; E8 is treated as an opcode: cmd=INX, len=1; no LDA entry ever appears.
- FLAG_ILLEGAL=1, stream 03 → cmd=NOP, mode=impl, len=1, instr_illegal=1; repeat with FLAG_ILLEGAL=0 → instr_illegal=0.
- Assert rst asynchronously between 4C and 34, mid-clock → outputs clear immediately; after release, stream EA → NOP entry with len=1, proving the FSM restarted in OPC.
